mini_core_mem_arb: RTL and testbench
====================================

# mini_core_mem_arb

Arbiter and sequencer sharing one single-port memory between mini_core instruction fetch (Q100H) and load/store (Q103H). It sets the fetch-stage enable (`FetchGnt`, which drives `ReadyQ100H`), the data-stage enable, and routes each read response back to its owner. A fetch response still in flight when the pipeline redirects is dropped. It sits between the mini_core pipeline and the shared I/D memory.

## Interface
- `STARVE_MAX`, 4: consecutive data grants allowed while fetch waits; the next grant then goes to fetch.
- `Clock` in 1: core clock.
- `RstN` in 1: reset, asynchronous, active-low.
- `FetchReq` in 1, `FetchAddr` in 32: fetch read request.
- `FetchGnt` out 1: fetch accepted this cycle; drives `ReadyQ100H`.
- `FetchRspValid` out 1, `FetchRspData` out 32: instruction returned.
- `DataReq` in 1, `DataWrEn` in 1, `DataAddr` in 32, `DataWrData` in 32, `DataByteEn` in 4: load/store request.
- `DataGnt` out 1: data request accepted this cycle.
- `DataRspValid` out 1, `DataRspData` out 32: load data returned.
- `Flush` in 1: pipeline redirect (`SelNextPcAluOutQ102H`).
- `MemReq` out 1, `MemAddr` out 32, `MemWrEn` out 1, `MemWrData` out 32, `MemByteEn` out 4: memory request.
- `MemAccept` in 1: memory takes the request this cycle.
- `MemRspValid` in 1, `MemRspData` in 32: read response.

## Operation
- FSM states:
  - IDLE: no read outstanding.
  - WAIT_I: fetch read outstanding.
  - WAIT_D: data read outstanding.
- Only one read is outstanding at a time.
- Issue window: the FSM is in IDLE, or it is in WAIT_x and `MemRspValid`=1 in that cycle (back-to-back issue).
- Outside the issue window: `MemReq`=0 and both grants are 0.
- Selection within the issue window:
  - Data wins by default.
  - Fetch wins when `StarveCnt`==`STARVE_MAX`, or when `DataReq`=0.
- `MemReq` = selected request is valid. The `Mem*` fields come from the selected requester. A fetch sends `MemWrEn`=0 and `MemByteEn`=4'hF.
- Grant to the selected requester = `MemReq & MemAccept`. If `MemAccept`=0, the requester holds its request and the selection is re-evaluated the next cycle.
- Next state on acceptance:
  - Fetch read → WAIT_I.
  - Data read → WAIT_D.
  - Data write → IDLE. Writes get no response.
- In WAIT_x, `MemRspValid`=1 with no new acceptance → IDLE.
- Response routing:
  - In WAIT_D: `DataRspValid` = `MemRspValid`.
  - In WAIT_I: `FetchRspValid` = `MemRspValid & ~DropQ`.
  - Response data passes straight through from `MemRspData`.
- `MemRspValid` in IDLE is ignored. Both response valids stay 0.
- `StarveCnt` (width clog2(`STARVE_MAX`+1)):
  - Increments on each `DataGnt` while `FetchReq`=1.
  - Clears on `FetchGnt`, or on any cycle with `FetchReq`=0.
  - Saturates at `STARVE_MAX`.
- `DropQ`:
  - Set when `Flush`=1 in WAIT_I.
  - Cleared when the WAIT_I response arrives.
  - `Flush` in the same cycle as a `FetchGnt` does not drop that new fetch, because its address is already the redirect target.
  - `Flush` in IDLE or WAIT_D has no effect.

## Timing
- Reset values:
  - State IDLE; `StarveCnt`=0; `DropQ`=0.
  - All outputs 0; statistics counters 0.
- Grants and `Mem*` are combinational from the requests, `MemAccept`, the state and `StarveCnt`.
- Response outputs are combinational from `MemRspValid`/`MemRspData` and the state.
- The earliest response comes one cycle after acceptance, so peak throughput is one read per cycle.
- Reset mid-operation returns to IDLE. A late response arriving after reset is discarded.

## Configuration
- `MINI_CORE_ARB_STATS_EN` defined:
  - Adds outputs `StatFetchStall` (32) and `StatDataGnt` (32).
  - `StatFetchStall` counts cycles with `FetchReq`=1 and `FetchGnt`=0.
  - `StatDataGnt` counts `DataGnt` cycles.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- `mini_core_pkg` holds:
  - `t_arb_state` enum {IDLE, WAIT_I, WAIT_D}.
  - `t_arb_req` struct {Valid, WrEn, Addr, WrData, ByteEn}, used for the selection mux.
  - A default for `STARVE_MAX`.
- Flops use `MAFIA_DFF`-style macros with async active-low reset.
- Single module; no sub-module.

## Test plan
- Fetch only, `MemAccept`=1, response one cycle later: `FetchGnt`=1 every other cycle, then every cycle once back-to-back issue starts. `FetchRspData`=`MemRspData`.
- Both requesting, `STARVE_MAX`=4: data granted 4 times, fetch on the 5th issue. `StarveCnt` returns to 0.
- Data store to 0x100 (`ByteEn`=4'h3) → `MemWrEn`=1, `DataGnt`=1, FSM stays IDLE, no `DataRspValid`. A fetch is granted the next cycle.
- Fetch accepted, `Flush`=1 next cycle, response 2 cycles later → `FetchRspValid` stays 0. A new fetch issues in the response cycle.
- `MemAccept`=0 for 3 cycles with both requesting → no grants, `Mem*` hold the data request. Accept on the 4th cycle → `DataGnt`.
- `RstN` pulsed in WAIT_D, then `MemRspValid` arrives → `DataRspValid`=0, state IDLE. With the macro on, `StatFetchStall`/`StatDataGnt` match the bench counts.

Source files
------------

// File: rtl/mini_core_pkg.sv
// Shared types for the mini_core memory arbiter: FSM states, request bundle
// used by the selection mux, and the default fetch-starvation limit.
package mini_core_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } t_arb_state;

  typedef struct packed {
    logic        Valid;
    logic        WrEn;
    logic [31:0] Addr;
    logic [31:0] WrData;
    logic [3:0]  ByteEn;
  } t_arb_req;

  localparam int unsigned ARB_STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/mini_core_mem_arb.sv
// Shares one single-port memory between fetch and load/store, one read in flight.
// Optional MINI_CORE_ARB_STATS_EN adds fetch-stall and data-grant counters.
//
// state  | meaning
// IDLE   | no read outstanding
// WAIT_I | fetch read outstanding
// WAIT_D | data read outstanding
`ifndef MAFIA_DFF
`define MAFIA_DFF(q, d, rst_val) always_ff @(posedge Clock or negedge RstN) if (!RstN) q <= (rst_val); else q <= (d);
`endif

module mini_core_mem_arb
  import mini_core_pkg::*;
#(
  parameter int unsigned STARVE_MAX = ARB_STARVE_MAX_DEFAULT
) (
  input  logic        Clock,
  input  logic        RstN,
  input  logic        FetchReq,
  input  logic [31:0] FetchAddr,
  output logic        FetchGnt,
  output logic        FetchRspValid,
  output logic [31:0] FetchRspData,
  input  logic        DataReq,
  input  logic        DataWrEn,
  input  logic [31:0] DataAddr,
  input  logic [31:0] DataWrData,
  input  logic [3:0]  DataByteEn,
  output logic        DataGnt,
  output logic        DataRspValid,
  output logic [31:0] DataRspData,
  input  logic        Flush,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  output logic        MemWrEn,
  output logic [31:0] MemWrData,
  output logic [3:0]  MemByteEn,
  input  logic        MemAccept,
  input  logic        MemRspValid,
  input  logic [31:0] MemRspData
`ifdef MINI_CORE_ARB_STATS_EN
  ,
  output logic [31:0] StatFetchStall,
  output logic [31:0] StatDataGnt
`endif
);

  localparam int unsigned     CntW   = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

  t_arb_state      StateQ, StateD;
  logic [CntW-1:0] StarveCntQ, StarveCntD;
  logic            DropQ, DropD;

  t_arb_req fetch_req, data_req, sel_req;
  logic     issue_win, fetch_sel, accept;

  always_comb begin
    fetch_req = '{Valid: FetchReq, WrEn: 1'b0, Addr: FetchAddr, WrData: 32'h0, ByteEn: 4'hF};
    data_req  = '{Valid: DataReq, WrEn: DataWrEn, Addr: DataAddr, WrData: DataWrData,
                  ByteEn: DataByteEn};

    // A response arriving this cycle frees the port, allowing back-to-back issue.
    issue_win = (StateQ == IDLE) || MemRspValid;
    fetch_sel = (StarveCntQ == CntMax) || !DataReq;
    sel_req   = fetch_sel ? fetch_req : data_req;

    MemReq    = issue_win && sel_req.Valid;
    accept    = MemReq && MemAccept;
    FetchGnt  = accept && fetch_sel;
    DataGnt   = accept && !fetch_sel;

    MemAddr   = MemReq ? sel_req.Addr   : 32'h0;
    MemWrEn   = MemReq ? sel_req.WrEn   : 1'b0;
    MemWrData = MemReq ? sel_req.WrData : 32'h0;
    MemByteEn = MemReq ? sel_req.ByteEn : 4'h0;
  end

  always_comb begin
    StateD = StateQ;
    if (accept) begin
      if (fetch_sel)         StateD = WAIT_I;
      else if (sel_req.WrEn) StateD = IDLE;
      else                   StateD = WAIT_D;
    end else if (StateQ != IDLE && MemRspValid) begin
      StateD = IDLE;
    end

    StarveCntD = StarveCntQ;
    if (FetchGnt || !FetchReq)                  StarveCntD = '0;
    else if (DataGnt && StarveCntQ != CntMax)   StarveCntD = StarveCntQ + CntW'(1);

    // A fetch granted alongside Flush already targets the redirect, so it is kept.
    DropD = 1'b0;
    if (StateQ == WAIT_I) DropD = MemRspValid ? 1'b0 : (DropQ || Flush);
  end

  always_comb begin
    DataRspValid  = (StateQ == WAIT_D) && MemRspValid;
    FetchRspValid = (StateQ == WAIT_I) && MemRspValid && !DropQ;
    DataRspData   = DataRspValid  ? MemRspData : 32'h0;
    FetchRspData  = FetchRspValid ? MemRspData : 32'h0;
  end

  `MAFIA_DFF(StateQ, StateD, IDLE)
  `MAFIA_DFF(StarveCntQ, StarveCntD, '0)
  `MAFIA_DFF(DropQ, DropD, 1'b0)

`ifdef MINI_CORE_ARB_STATS_EN
  logic [31:0] StatStallQ, StatDGntQ;

  `MAFIA_DFF(StatStallQ, StatStallQ + 32'(FetchReq && !FetchGnt), 32'h0)
  `MAFIA_DFF(StatDGntQ, StatDGntQ + 32'(DataGnt), 32'h0)

  assign StatFetchStall = StatStallQ;
  assign StatDataGnt    = StatDGntQ;
`endif

endmodule

// File: tb/tb_mini_core_mem_arb.sv
// Directed bench for mini_core_mem_arb; build with or without MINI_CORE_ARB_STATS_EN.
module tb_mini_core_mem_arb;
  import mini_core_pkg::*;

  logic        Clock = 1'b0;
  logic        RstN;
  logic        FetchReq, DataReq, DataWrEn, Flush, MemAccept, MemRspValid;
  logic [31:0] FetchAddr, DataAddr, DataWrData, MemRspData;
  logic [3:0]  DataByteEn;
  logic        FetchGnt, FetchRspValid, DataGnt, DataRspValid, MemReq, MemWrEn;
  logic [31:0] FetchRspData, DataRspData, MemAddr, MemWrData;
  logic [3:0]  MemByteEn;
`ifdef MINI_CORE_ARB_STATS_EN
  logic [31:0] StatFetchStall, StatDataGnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int exp_stall = 0;
  int exp_dgnt  = 0;

  mini_core_mem_arb dut (
    .Clock(Clock), .RstN(RstN),
    .FetchReq(FetchReq), .FetchAddr(FetchAddr), .FetchGnt(FetchGnt),
    .FetchRspValid(FetchRspValid), .FetchRspData(FetchRspData),
    .DataReq(DataReq), .DataWrEn(DataWrEn), .DataAddr(DataAddr),
    .DataWrData(DataWrData), .DataByteEn(DataByteEn), .DataGnt(DataGnt),
    .DataRspValid(DataRspValid), .DataRspData(DataRspData),
    .Flush(Flush),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemWrEn(MemWrEn),
    .MemWrData(MemWrData), .MemByteEn(MemByteEn),
    .MemAccept(MemAccept), .MemRspValid(MemRspValid), .MemRspData(MemRspData)
`ifdef MINI_CORE_ARB_STATS_EN
    , .StatFetchStall(StatFetchStall), .StatDataGnt(StatDataGnt)
`endif
  );

  always #5 Clock = ~Clock;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input t_arb_state exp);
    chk32(tag, 32'(dut.StateQ), 32'(exp));
  endtask

  // Checks this cycle's grants, books expected stats, then crosses the clock edge.
  task automatic cyc(input string tag, input logic fg, input logic dg);
    chk1({tag, ".fgnt"}, FetchGnt, fg);
    chk1({tag, ".dgnt"}, DataGnt, dg);
    if (FetchReq && !fg) exp_stall++;
    if (dg) exp_dgnt++;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    RstN = 1'b0;
    FetchReq = 0; FetchAddr = 0; DataReq = 0; DataWrEn = 0; DataAddr = 0;
    DataWrData = 0; DataByteEn = 0; Flush = 0; MemAccept = 0;
    MemRspValid = 0; MemRspData = 0;
    #2;
    chk_st("rst.state", IDLE);
    chk1("rst.memreq", MemReq, 1'b0);
    chk32("rst.memaddr", MemAddr, 32'h0);
    chk32("rst.byteen", 32'(MemByteEn), 32'h0);
    chk1("rst.fgnt", FetchGnt, 1'b0);
    chk1("rst.frsp", FetchRspValid, 1'b0);
    chk1("rst.drsp", DataRspValid, 1'b0);
    chk32("rst.starve", 32'(dut.StarveCntQ), 32'h0);
    chk1("rst.drop", dut.DropQ, 1'b0);
`ifdef MINI_CORE_ARB_STATS_EN
    chk32("rst.stat_stall", StatFetchStall, 32'h0);
    chk32("rst.stat_dgnt", StatDataGnt, 32'h0);
`endif
    @(posedge Clock); #1;
    RstN = 1'b1;

    // Fetch only: grant, one dead cycle, then back-to-back issue on each response
    FetchReq = 1; FetchAddr = 32'h0; MemAccept = 1; #1;
    chk1("t1a.memreq", MemReq, 1'b1);
    chk32("t1a.memaddr", MemAddr, 32'h0);
    chk32("t1a.byteen", 32'(MemByteEn), 32'hF);
    chk1("t1a.wren", MemWrEn, 1'b0);
    cyc("t1a", 1, 0);
    #1;
    chk_st("t1b.state", WAIT_I);
    chk1("t1b.memreq", MemReq, 1'b0);
    cyc("t1b", 0, 0);
    FetchAddr = 32'h4; MemRspValid = 1; MemRspData = 32'hDEAD_0001; #1;
    chk1("t1c.frsp", FetchRspValid, 1'b1);
    chk32("t1c.fdata", FetchRspData, 32'hDEAD_0001);
    chk32("t1c.memaddr", MemAddr, 32'h4);
    cyc("t1c", 1, 0);
    FetchAddr = 32'h8; MemRspData = 32'hDEAD_0002; #1;
    chk1("t1d.frsp", FetchRspValid, 1'b1);
    chk32("t1d.fdata", FetchRspData, 32'hDEAD_0002);
    cyc("t1d", 1, 0);
    FetchReq = 0; MemRspData = 32'hDEAD_0003; #1;
    chk1("t1e.frsp", FetchRspValid, 1'b1);
    chk1("t1e.memreq", MemReq, 1'b0);
    cyc("t1e", 0, 0);
    #1;
    chk_st("t1f.state", IDLE);
    chk1("t1f.frsp_idle", FetchRspValid, 1'b0);
    chk1("t1f.drsp_idle", DataRspValid, 1'b0);
    cyc("t1f", 0, 0);
    MemRspValid = 0;

    // Both requesting: four data reads, then fetch on the fifth issue
    FetchReq = 1; FetchAddr = 32'h40; DataReq = 1; DataWrEn = 0; DataAddr = 32'h200; #1;
    chk32("t2_1.memaddr", MemAddr, 32'h200);
    cyc("t2_1", 0, 1);
    for (int i = 2; i <= 4; i++) begin
      MemRspValid = 1; MemRspData = 32'hD0 + 32'(i); #1;
      chk1($sformatf("t2_%0d.drsp", i), DataRspValid, 1'b1);
      chk32($sformatf("t2_%0d.ddata", i), DataRspData, 32'hD0 + 32'(i));
      chk32($sformatf("t2_%0d.memaddr", i), MemAddr, 32'h200);
      cyc($sformatf("t2_%0d", i), 0, 1);
    end
    MemRspData = 32'hD5; #1;
    chk32("t2_5.starve", 32'(dut.StarveCntQ), 32'd4);
    chk1("t2_5.drsp", DataRspValid, 1'b1);
    chk32("t2_5.memaddr", MemAddr, 32'h40);
    chk32("t2_5.byteen", 32'(MemByteEn), 32'hF);
    cyc("t2_5", 1, 0);
    FetchReq = 0; MemRspData = 32'h11; #1;
    chk32("t2_6.starve", 32'(dut.StarveCntQ), 32'd0);
    chk1("t2_6.frsp", FetchRspValid, 1'b1);
    chk32("t2_6.fdata", FetchRspData, 32'h11);
    chk1("t2_6.drsp", DataRspValid, 1'b0);
    cyc("t2_6", 0, 1);
    DataReq = 0; MemRspData = 32'h22; #1;
    chk1("t2_7.drsp", DataRspValid, 1'b1);
    chk1("t2_7.frsp", FetchRspValid, 1'b0);
    cyc("t2_7", 0, 0);
    MemRspValid = 0;

    // Store: no response, stays IDLE, fetch follows next cycle
    FetchReq = 1; FetchAddr = 32'h80;
    DataReq = 1; DataWrEn = 1; DataAddr = 32'h100; DataWrData = 32'hCAFE_BABE; DataByteEn = 4'h3; #1;
    chk1("t3a.wren", MemWrEn, 1'b1);
    chk32("t3a.byteen", 32'(MemByteEn), 32'h3);
    chk32("t3a.wdata", MemWrData, 32'hCAFE_BABE);
    chk32("t3a.memaddr", MemAddr, 32'h100);
    cyc("t3a", 0, 1);
    DataReq = 0; DataWrEn = 0; #1;
    chk_st("t3b.state", IDLE);
    chk1("t3b.drsp", DataRspValid, 1'b0);
    chk32("t3b.memaddr", MemAddr, 32'h80);
    cyc("t3b", 1, 0);

    // Flush while the fetch at 0x80 is in flight drops its response
    FetchReq = 0; Flush = 1; #1;
    chk1("t4a.memreq", MemReq, 1'b0);
    cyc("t4a", 0, 0);
    Flush = 0; #1;
    chk1("t4b.drop", dut.DropQ, 1'b1);
    cyc("t4b", 0, 0);
    MemRspValid = 1; MemRspData = 32'hBAD; FetchReq = 1; FetchAddr = 32'h300; Flush = 1; #1;
    chk1("t4c.frsp_dropped", FetchRspValid, 1'b0);
    chk32("t4c.memaddr", MemAddr, 32'h300);
    cyc("t4c", 1, 0);
    FetchReq = 0; Flush = 0; MemRspData = 32'h1234; #1;
    chk1("t4d.frsp_kept", FetchRspValid, 1'b1);
    chk32("t4d.fdata", FetchRspData, 32'h1234);
    cyc("t4d", 0, 0);
    MemRspValid = 0; Flush = 1; #1;
    cyc("t4e", 0, 0);
    Flush = 0; #1;
    chk1("t4f.drop_idle", dut.DropQ, 1'b0);
    cyc("t4f", 0, 0);

    // Memory back-pressure holds the data request until accepted
    FetchReq = 1; FetchAddr = 32'h500; DataReq = 1; DataAddr = 32'h600; MemAccept = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1($sformatf("t5_%0d.memreq", i), MemReq, 1'b1);
      chk32($sformatf("t5_%0d.memaddr", i), MemAddr, 32'h600);
      cyc($sformatf("t5_%0d", i), 0, 0);
    end
    MemAccept = 1; #1;
    chk32("t5_3.starve", 32'(dut.StarveCntQ), 32'd0);
    cyc("t5_3", 0, 1);

    // Reset while a data read is outstanding; the late response is ignored
    FetchReq = 0; DataReq = 0; #1;
    chk_st("t6a.state", WAIT_D);
`ifdef MINI_CORE_ARB_STATS_EN
    chk32("t6a.stat_stall", StatFetchStall, 32'(exp_stall));
    chk32("t6a.stat_dgnt", StatDataGnt, 32'(exp_dgnt));
`endif
    RstN = 1'b0; #1;
    chk_st("t6b.state", IDLE);
    @(posedge Clock); #1;
    RstN = 1'b1; exp_stall = 0; exp_dgnt = 0;
    MemRspValid = 1; MemRspData = 32'h77; #1;
    chk1("t6c.drsp", DataRspValid, 1'b0);
    chk32("t6c.ddata", DataRspData, 32'h0);
    chk1("t6c.frsp", FetchRspValid, 1'b0);
`ifdef MINI_CORE_ARB_STATS_EN
    chk32("t6c.stat_stall", StatFetchStall, 32'h0);
    chk32("t6c.stat_dgnt", StatDataGnt, 32'h0);
`endif
    cyc("t6c", 0, 0);
    MemRspValid = 0; #1;
    chk_st("t6d.state", IDLE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
